// File: rtl/lcd_write_arbiter.sv
// Two-port round-robin byte arbiter feeding a small FIFO, drained one byte per
// ready / data-ready handshake into the LCD character controller.
module lcd_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iReq0,
  input  logic [7:0]    iData0,
  output logic          oAck0,
  input  logic          iReq1,
  input  logic [7:0]    iData1,
  output logic          oAck1,
  input  logic          iLCD_Ready,
  output logic [7:0]    oLCD_Data,
  output logic          oLCD_DataReady,
  output logic          oFull,
  output logic          oEmpty,
  output logic [AW:0]   oCount
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_SEND  = 2'd1;
  localparam logic [1:0]  ST_WAIT  = 2'd2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [1:0]    state_r;
  logic          last_r;
  logic [7:0]    lcd_data_r;
  logic          lcd_dr_r;

  logic          full_s;
  logic          empty_s;
  logic          grant0_s;
  logic          grant1_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    push_data_s;
  logic [1:0]    state_next_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {(AW+1){1'b0}});

  // Grant from the registered count only, so a pop never frees space for a same-cycle push.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!Reset && !full_s) begin
      if (iReq0 && iReq1) begin
        if (last_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        grant0_s = iReq0;
        grant1_s = iReq1;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign push_s      = grant0_s | grant1_s;
  assign push_data_s = grant1_s ? iData1 : iData0;
  assign pop_s       = (state_r == ST_SEND);

  // Drain FSM: SEND lasts one cycle; WAIT needs the controller to go busy before re-arming.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && iLCD_Ready) begin
          state_next_s = ST_SEND;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (!iLCD_Ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge Clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Pointers, occupancy, arbitration history and the LCD-facing registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      state_r    <= ST_IDLE;
      last_r     <= 1'b1;
      lcd_data_r <= 8'h00;
      lcd_dr_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        last_r   <= grant1_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      state_r <= state_next_s;
      if (state_r == ST_IDLE && state_next_s == ST_SEND) begin
        lcd_data_r <= mem_r[rd_ptr_r];
      end
      lcd_dr_r <= (state_next_s == ST_SEND);
    end
  end

  assign oAck0          = grant0_s;
  assign oAck1          = grant1_s;
  assign oLCD_Data      = lcd_data_r;
  assign oLCD_DataReady = lcd_dr_r;
  assign oFull          = full_s;
  assign oEmpty         = empty_s;
  assign oCount         = count_r;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed vector table, hand sequences and a
// random run, all checked against a queue-based reference model.
module tb_lcd_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iReq0, iReq1, iLCD_Ready;
  logic [7:0]    iData0, iData1;
  logic          oAck0, oAck1, oLCD_DataReady, oFull, oEmpty;
  logic [7:0]    oLCD_Data;
  logic [AW:0]   oCount;

  lcd_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq0(iReq0), .iData0(iData0), .oAck0(oAck0),
    .iReq1(iReq1), .iData1(iData1), .oAck1(oAck1),
    .iLCD_Ready(iLCD_Ready), .oLCD_Data(oLCD_Data), .oLCD_DataReady(oLCD_DataReady),
    .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount)
  );

  always #10 Clock = ~Clock;

  int total  = 0;
  int passed = 0;

  // Reference model: a byte queue plus handshake bookkeeping.
  logic [7:0] q[$];
  bit         last;
  bit         armed;
  bit         strobe_now;
  logic [7:0] last_data;
  bit         m_ack0, m_ack1;

  // Values sampled from the DUT in the most recent step.
  logic       s_ack0, s_ack1, s_dr;
  logic [7:0] s_data;
  logic [AW:0] s_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    last       = 1'b1;
    armed      = 1'b1;
    strobe_now = 1'b0;
    last_data  = 8'h00;
  endtask

  task automatic step(input bit rst, input bit r0, input logic [7:0] d0,
                      input bit r1, input logic [7:0] d1, input bit rdy);
    int size_before;
    bit idle, nxt;
    logic [7:0] exp_data;
    @(negedge Clock);
    Reset = rst; iReq0 = r0; iData0 = d0; iReq1 = r1; iData1 = d1; iLCD_Ready = rdy;
    #1;
    size_before = q.size();
    m_ack0 = 1'b0; m_ack1 = 1'b0;
    if (!rst && size_before < DEPTH) begin
      if (r0 && r1) begin
        m_ack0 = last;
        m_ack1 = !last;
      end else begin
        m_ack0 = r0;
        m_ack1 = r1;
      end
    end
    exp_data = (strobe_now && size_before > 0) ? q[0] : last_data;
    s_ack0 = oAck0; s_ack1 = oAck1; s_dr = oLCD_DataReady; s_data = oLCD_Data; s_count = oCount;
    chk("ack0", 32'(oAck0), 32'(m_ack0));
    chk("ack1", 32'(oAck1), 32'(m_ack1));
    chk("data_ready", 32'(oLCD_DataReady), 32'(strobe_now));
    chk("lcd_data", 32'(oLCD_Data), 32'(exp_data));
    chk("count", 32'(oCount), 32'(size_before));
    chk("full", 32'(oFull), 32'(size_before == DEPTH));
    chk("empty", 32'(oEmpty), 32'(size_before == 0));
    if (rst) begin
      model_reset();
    end else begin
      if (strobe_now && size_before > 0) begin
        last_data = q[0];
        void'(q.pop_front());
      end
      if (m_ack0) begin q.push_back(d0); last = 1'b0; end
      if (m_ack1) begin q.push_back(d1); last = 1'b1; end
      idle = !strobe_now && armed;
      nxt  = idle && size_before > 0 && rdy;
      if (strobe_now) armed = 1'b0;
      else if (!rdy) armed = 1'b1;
      strobe_now = nxt;
    end
  endtask

  typedef struct {
    bit r0; logic [7:0] d0; bit r1; logic [7:0] d1; bit rdy;
    bit a0; bit a1; bit dr; logic [7:0] data; int cnt;
  } vec_t;

  vec_t tbl[19];

  bit         p0, p1, rr;
  logic [7:0] pd0, pd1;

  initial begin
    tbl[0]  = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b1, 8'h11, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3};
    tbl[4]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4};
    tbl[5]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4};
    tbl[6]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 4};
    tbl[7]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 3};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 4};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 4};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 3};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 2};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 2};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 2};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 2};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 2};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21, 1};

    // Reset held two cycles with both requesters active: no acks allowed.
    Reset = 1'b1; iReq0 = 1'b1; iReq1 = 1'b1; iData0 = 8'hAA; iData1 = 8'hBB; iLCD_Ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock); #1;
      chk("rst_ack0", 32'(oAck0), 32'd0);
      chk("rst_ack1", 32'(oAck1), 32'd0);
    end
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_empty", 32'(oEmpty), 32'd1);
    chk("rst_full", 32'(oFull), 32'd0);
    chk("rst_dr", 32'(oLCD_DataReady), 32'd0);
    chk("rst_data", 32'(oLCD_Data), 32'd0);
    Reset = 1'b0; iReq0 = 1'b0; iReq1 = 1'b0;
    model_reset();

    // Round-robin fill to full, pop/push interplay, handshake hold.
    for (int i = 0; i < 19; i++) begin
      step(1'b0, tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].rdy);
      chk($sformatf("tbl%0d_ack0", i), 32'(s_ack0), 32'(tbl[i].a0));
      chk($sformatf("tbl%0d_ack1", i), 32'(s_ack1), 32'(tbl[i].a1));
      chk($sformatf("tbl%0d_dr", i), 32'(s_dr), 32'(tbl[i].dr));
      chk($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].cnt));
    end

    // Single byte: ack in cycle 1, strobe with 0x41 in cycle 3, FIFO empty after.
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    chk("single_ack", 32'(s_ack0), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("single_no_early", 32'(s_dr), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("single_dr", 32'(s_dr), 32'd1);
    chk("single_data", 32'(s_data), 32'h41);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("single_count", 32'(s_count), 32'd0);
    chk("single_one_pulse", 32'(s_dr), 32'd0);

    // Reset while SEND with two bytes queued.
    step(1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hB1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("midrst_in_send", 32'(s_dr), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("midrst_count", 32'(s_count), 32'd0);
    chk("midrst_dr", 32'(s_dr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, i[0]);
      chk("midrst_no_strobe", 32'(s_dr), 32'd0);
    end

    // Random traffic against the model.
    p0 = 1'b0; p1 = 1'b0; pd0 = 8'h00; pd1 = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1'b1; pd0 = 8'($urandom); end
      if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1'b1; pd1 = 8'($urandom); end
      rr = ($urandom_range(0, 299) == 0);
      step(rr, p0, pd0, p1, pd1, $urandom_range(0, 3) != 0);
      if (m_ack0) p0 = 1'b0;
      if (m_ack1) p1 = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
